// File: rtl/cavlc_coeff_token_dec.sv
// cavlc_coeff_token_dec: sequential CAVLC coeff_token decoder.
// ChromaDC (nC = -1) and fixed-length (nC >= 8) tokens are decoded here;
// VLC tables (0 <= nC < 8) are delegated to an external LUT bank over a
// request/acknowledge port. Results leave on a valid/ready port together
// with the number of bits consumed.
module cavlc_coeff_token_dec #(
  parameter int unsigned WINDOW_W = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic                InValid,
  output logic                InReady,
  input  logic [WINDOW_W-1:0] Window,
  input  logic [5:0]          nC,
  output logic                LutReq,
  output logic [1:0]          LutTable,
  output logic [15:0]         LutBits,
  input  logic                LutAck,
  input  logic [4:0]          LutTotalCoeff,
  input  logic [1:0]          LutTrailingOnes,
  input  logic [4:0]          LutLength,
  input  logic                LutError,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [4:0]          TotalCoeff,
  output logic [1:0]          TrailingOnes,
  output logic [4:0]          Length,
  output logic                Error,
  output logic [CNT_W-1:0]    TokenCount
);

  typedef enum logic [1:0] {IDLE, DECODE, LUT_WAIT, OUT} state_e;

  state_e             state_q, state_d;
  logic [15:0]        win_q, win_d;
  logic [5:0]         nc_q, nc_d;
  logic [4:0]         tc_q, tc_d;
  logic [1:0]         t1_q, t1_d;
  logic [4:0]         len_q, len_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         lut_table_q, lut_table_d;
  logic [15:0]        lut_bits_q, lut_bits_d;

  logic [4:0]         cd_tc, cd_len, flc_tc;
  logic [1:0]         cd_t1, flc_t1;
  logic               flc_err;

  // ChromaDC prefix decode on the captured window (prefix set is complete)
  always_comb begin
    cd_tc  = '0;
    cd_t1  = '0;
    cd_len = '0;
    casez (win_q[15:8])
      8'b1???????: begin cd_t1 = 2'd1; cd_tc = 5'd1; cd_len = 5'd1; end
      8'b01??????: begin cd_t1 = 2'd0; cd_tc = 5'd0; cd_len = 5'd2; end
      8'b001?????: begin cd_t1 = 2'd2; cd_tc = 5'd2; cd_len = 5'd3; end
      8'b000111??: begin cd_t1 = 2'd0; cd_tc = 5'd1; cd_len = 5'd6; end
      8'b000110??: begin cd_t1 = 2'd1; cd_tc = 5'd2; cd_len = 5'd6; end
      8'b000101??: begin cd_t1 = 2'd3; cd_tc = 5'd3; cd_len = 5'd6; end
      8'b000100??: begin cd_t1 = 2'd0; cd_tc = 5'd2; cd_len = 5'd6; end
      8'b000011??: begin cd_t1 = 2'd0; cd_tc = 5'd3; cd_len = 5'd6; end
      8'b000010??: begin cd_t1 = 2'd0; cd_tc = 5'd4; cd_len = 5'd6; end
      8'b0000011?: begin cd_t1 = 2'd1; cd_tc = 5'd3; cd_len = 5'd7; end
      8'b0000010?: begin cd_t1 = 2'd2; cd_tc = 5'd3; cd_len = 5'd7; end
      8'b00000011: begin cd_t1 = 2'd1; cd_tc = 5'd4; cd_len = 5'd8; end
      8'b00000010: begin cd_t1 = 2'd2; cd_tc = 5'd4; cd_len = 5'd8; end
      default:     begin cd_t1 = 2'd3; cd_tc = 5'd4; cd_len = 5'd7; end
    endcase
  end

  // Fixed-length decode: xxxxyy, with 000011 reserved for the empty token
  always_comb begin
    flc_tc  = {1'b0, win_q[15:12]} + 5'd1;
    flc_t1  = win_q[11:10];
    flc_err = ({3'b000, win_q[11:10]} > flc_tc);
    if (win_q[15:10] == 6'b000011) begin
      flc_tc  = '0;
      flc_t1  = '0;
      flc_err = 1'b0;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    nc_d        = nc_q;
    tc_d        = tc_q;
    t1_d        = t1_q;
    len_d       = len_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    lut_table_d = lut_table_q;
    lut_bits_d  = lut_bits_q;
    unique case (state_q)
      IDLE: begin
        if (InValid) begin
          win_d   = Window[WINDOW_W-1 -: 16];
          nc_d    = nC;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (nc_q == 6'b111111) begin
          tc_d    = cd_tc;
          t1_d    = cd_t1;
          len_d   = cd_len;
          err_d   = 1'b0;
          state_d = OUT;
        end else if (!nc_q[5] && (nc_q[4:3] != 2'b00)) begin
          tc_d    = flc_tc;
          t1_d    = flc_t1;
          len_d   = 5'd6;
          err_d   = flc_err;
          state_d = OUT;
        end else if (!nc_q[5]) begin
          lut_table_d = nc_q[2] ? 2'd2 : (nc_q[1] ? 2'd1 : 2'd0);
          lut_bits_d  = win_q;
          state_d     = LUT_WAIT;
        end else begin
          tc_d    = '0;
          t1_d    = '0;
          len_d   = '0;
          err_d   = 1'b1;
          state_d = OUT;
        end
      end
      LUT_WAIT: begin
        if (LutAck) begin
          tc_d    = LutTotalCoeff;
          t1_d    = LutTrailingOnes;
          len_d   = LutLength;
          err_d   = LutError;
          state_d = OUT;
        end
      end
      OUT: begin
        if (OutReady) begin
          if (!err_q) cnt_d = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      win_q       <= '0;
      nc_q        <= '0;
      tc_q        <= '0;
      t1_q        <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      lut_table_q <= '0;
      lut_bits_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      nc_q        <= nc_d;
      tc_q        <= tc_d;
      t1_q        <= t1_d;
      len_q       <= len_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      lut_table_q <= lut_table_d;
      lut_bits_q  <= lut_bits_d;
    end
  end

  assign InReady      = (state_q == IDLE);
  assign LutReq       = (state_q == LUT_WAIT);
  assign OutValid     = (state_q == OUT);
  assign LutTable     = lut_table_q;
  assign LutBits      = lut_bits_q;
  assign TotalCoeff   = tc_q;
  assign TrailingOnes = t1_q;
  assign Length       = len_q;
  assign Error        = err_q;
  assign TokenCount   = cnt_q;

endmodule

// File: tb/tb_cavlc_coeff_token_dec.sv
// Scoreboard bench for cavlc_coeff_token_dec: a driver issues tokens and
// pushes expected results, a LUT responder models the external table bank,
// and a monitor pops and compares whenever the DUT presents a result.
module tb_cavlc_coeff_token_dec;

  localparam int WW = 16;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          nReset = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [WW-1:0] Window = '0;
  logic [5:0]    nC = '0;
  logic          LutReq;
  logic [1:0]    LutTable;
  logic [15:0]   LutBits;
  logic          LutAck = 1'b0;
  logic [4:0]    LutTotalCoeff = '0;
  logic [1:0]    LutTrailingOnes = '0;
  logic [4:0]    LutLength = '0;
  logic          LutError = 1'b0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [4:0]    TotalCoeff;
  logic [1:0]    TrailingOnes;
  logic [4:0]    Length;
  logic          Error;
  logic [CW-1:0] TokenCount;

  cavlc_coeff_token_dec #(.WINDOW_W(WW), .CNT_W(CW)) dut (
    .Clk(Clk), .nReset(nReset), .InValid(InValid), .InReady(InReady),
    .Window(Window), .nC(nC), .LutReq(LutReq), .LutTable(LutTable),
    .LutBits(LutBits), .LutAck(LutAck), .LutTotalCoeff(LutTotalCoeff),
    .LutTrailingOnes(LutTrailingOnes), .LutLength(LutLength),
    .LutError(LutError), .OutValid(OutValid), .OutReady(OutReady),
    .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .Length(Length),
    .Error(Error), .TokenCount(TokenCount)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] tc; logic [1:0] t1; logic [4:0] len; logic err;
    bit internal; int hold; int acc;
  } exp_t;

  typedef struct {
    logic [4:0] tc; logic [1:0] t1; logic [4:0] len; logic err;
    int dly; logic [1:0] tbl; logic [15:0] bits; int acc;
  } lut_t;

  exp_t expq[$];
  lut_t lutq[$];

  int n_vec = 0;
  int n_err = 0;
  int rst_count = 0;
  int resp_mode = 0;   // 0 normal, 1 silent, 2 stuck ack
  logic [CW-1:0] cnt_model = '0;

  // ChromaDC code table: code value (right-aligned), length, T1s, TotalCoeff
  int clen [14] = '{2, 1, 6, 6, 6, 3, 6, 7, 7, 6, 6, 8, 8, 7};
  int cval [14] = '{1, 1, 7, 4, 6, 1, 3, 3, 2, 5, 2, 3, 2, 0};
  int ct1  [14] = '{0, 1, 0, 0, 1, 2, 0, 1, 2, 3, 0, 1, 2, 3};
  int ctc  [14] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] w, input int nc, input lut_t l);
    exp_t e;
    int x, y;
    e.internal = 1'b1; e.hold = 0; e.acc = 0;
    e.tc = '0; e.t1 = '0; e.len = '0; e.err = 1'b0;
    if (nc == -1) begin
      for (int i = 0; i < 14; i++)
        if ((int'(w) >> (16 - clen[i])) == cval[i]) begin
          e.tc = 5'(ctc[i]); e.t1 = 2'(ct1[i]); e.len = 5'(clen[i]);
        end
    end else if (nc >= 8) begin
      x = int'(w) / 4096;
      y = (int'(w) / 1024) % 4;
      e.len = 5'd6;
      if (x == 0 && y == 3) begin
        e.tc = '0; e.t1 = '0;
      end else begin
        e.tc = 5'(x + 1); e.t1 = 2'(y); e.err = (y > x + 1);
      end
    end else if (nc >= 0) begin
      e.tc = l.tc; e.t1 = l.t1; e.len = l.len; e.err = l.err; e.internal = 1'b0;
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic lut_t rand_lut();
    lut_t l;
    l.tc = 5'($urandom_range(16)); l.t1 = 2'($urandom_range(3));
    l.len = 5'($urandom_range(16, 1)); l.err = ($urandom_range(7) == 0);
    l.dly = 0; l.tbl = '0; l.bits = '0; l.acc = 0;
    return l;
  endfunction

  // Present one token (called on a falling edge) and record its expectations
  task automatic issue(input logic [15:0] w, input int nc, input int hold,
                       input int dly, input lut_t l);
    exp_t e;
    lut_t le;
    int n, acc;
    InValid = 1'b1; Window = w; nC = 6'(nc);
    n = 0;
    while (!InReady && n < 200) begin @(negedge Clk); n++; end
    if (!InReady) chk("accept_timeout", 32'd0, 32'd1);
    acc = cyc;
    @(negedge Clk);
    InValid = 1'b0; Window = 16'($urandom); nC = 6'($urandom);
    e = model(w, nc, l); e.acc = acc; e.hold = hold;
    expq.push_back(e);
    if (nc >= 0 && nc < 8) begin
      le = l; le.dly = dly; le.bits = w; le.acc = acc;
      le.tbl = (nc < 2) ? 2'd0 : (nc < 4) ? 2'd1 : 2'd2;
      lutq.push_back(le);
    end
  endtask

  // Monitor: compares every presented result and tracks the token counter
  initial begin
    exp_t cur;
    bit holding, post;
    int rs_seen;
    holding = 0; post = 0; rs_seen = 0;
    cur.tc = '0; cur.t1 = '0; cur.len = '0; cur.err = 1'b0;
    cur.internal = 1'b0; cur.hold = 0; cur.acc = 0;
    forever begin
      @(negedge Clk);
      if (rst_count != rs_seen) begin
        rs_seen = rst_count; cnt_model = '0; holding = 0; post = 0;
      end
      chk("token_count", 32'(TokenCount), 32'(cnt_model));
      if (post) begin
        chk("inready_after_hs", 32'(InReady), 32'd1);
        post = 0;
      end
      if (OutValid) begin
        if (!holding) begin
          if (expq.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
            cur.tc = '0; cur.t1 = '0; cur.len = '0; cur.err = 1'b0;
            cur.internal = 1'b0; cur.hold = 0;
          end else begin
            cur = expq.pop_front();
            if (cur.internal) chk("internal_latency", 32'(cyc), 32'(cur.acc + 2));
          end
          holding = 1;
        end
        chk("total_coeff", 32'(TotalCoeff), 32'(cur.tc));
        chk("trailing_ones", 32'(TrailingOnes), 32'(cur.t1));
        chk("length", 32'(Length), 32'(cur.len));
        chk("error", 32'(Error), 32'(cur.err));
        chk("inready_busy", 32'(InReady), 32'd0);
        if (cur.hold > 0) begin
          OutReady = 1'b0; cur.hold--;
        end else begin
          OutReady = ($urandom_range(3) != 0);
        end
        if (OutReady) begin
          if (!cur.err) cnt_model = cnt_model + 1'b1;
          holding = 0; post = 1;
        end
      end else begin
        if (holding) begin
          chk("outvalid_dropped", 32'd0, 32'd1);
          holding = 0;
        end
        OutReady = $urandom_range(1);
      end
    end
  end

  // LUT bank responder, with spurious acks while no request is pending
  initial begin
    lut_t le;
    forever begin
      @(negedge Clk);
      if (resp_mode == 1) begin
        LutAck = 1'b0;
      end else if (resp_mode == 2) begin
        LutAck = 1'b1; LutTotalCoeff = 5'($urandom); LutTrailingOnes = 2'($urandom);
        LutLength = 5'($urandom); LutError = 1'($urandom);
      end else if (LutReq) begin
        if (lutq.size() == 0) begin
          chk("unexpected_lut_req", 32'd1, 32'd0);
          le = rand_lut();
        end else begin
          le = lutq.pop_front();
          chk("lut_table", 32'(LutTable), 32'(le.tbl));
          chk("lut_bits", 32'(LutBits), 32'(le.bits));
          chk("lut_req_latency", 32'(cyc), 32'(le.acc + 2));
        end
        for (int k = 0; k < le.dly; k++) begin
          LutAck = 1'b0; LutTotalCoeff = 5'($urandom); LutLength = 5'($urandom);
          @(negedge Clk);
          chk("lutreq_held", 32'(LutReq), 32'd1);
          chk("lutbits_stable", 32'(LutBits), 32'(le.bits));
          chk("lut_out_early", 32'(OutValid), 32'd0);
        end
        LutAck = 1'b1; LutTotalCoeff = le.tc; LutTrailingOnes = le.t1;
        LutLength = le.len; LutError = le.err;
        @(negedge Clk);
        LutAck = 1'b0;
        chk("lutreq_drop", 32'(LutReq), 32'd0);
        chk("lut_outvalid", 32'(OutValid), 32'd1);
      end else begin
        LutAck = ($urandom_range(3) == 0); LutTotalCoeff = 5'($urandom);
        LutTrailingOnes = 2'($urandom); LutLength = 5'($urandom); LutError = 1'($urandom);
      end
    end
  end

  initial begin
    #600000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Main stimulus
  initial begin
    lut_t z, l5;
    logic [15:0] w;
    int nc, r, n, i;
    z = rand_lut(); z.tc = '0; z.t1 = '0; z.len = '0; z.err = 1'b0;
    l5 = z; l5.tc = 5'd9; l5.len = 5'd14;

    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    @(negedge Clk);
    chk("rst_inready", 32'(InReady), 32'd1);
    chk("rst_lutreq", 32'(LutReq), 32'd0);
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_fields", 32'({TotalCoeff, TrailingOnes, Length, Error}), 32'd0);
    chk("rst_count", 32'(TokenCount), 32'd0);
    chk("rst_lut_port", 32'({LutTable, LutBits}), 32'd0);

    issue(16'h0E00, -1, 0, 0, z);
    issue(16'hB800, 10, 0, 0, z);
    issue(16'h0C00, 10, 0, 0, z);
    issue(16'h1C00, 10, 0, 0, z);
    issue(16'h0800, 20, 0, 0, z);
    issue(16'h0F00, 5, 0, 3, l5);
    issue(16'hFFFF, -3, 0, 0, z);
    issue(16'h4000, -1, 5, 0, z);
    issue(16'h0300, -1, 0, 0, z);
    issue(16'h1234, 0, 0, 0, rand_lut());
    issue(16'h8765, 3, 0, 1, rand_lut());

    // Reset while a LUT request is outstanding
    n = 0;
    while ((expq.size() != 0 || lutq.size() != 0 || !InReady) && n < 500) begin
      @(negedge Clk); n++;
    end
    #1 resp_mode = 1;
    @(negedge Clk);
    InValid = 1'b1; Window = 16'h3A5C; nC = 6'd3;
    @(negedge Clk);
    InValid = 1'b0;
    n = 0;
    while (!LutReq && n < 10) begin @(negedge Clk); n++; end
    chk("rst_lutreq_pending", 32'(LutReq), 32'd1);
    chk("rst_lutbits_pending", 32'(LutBits), 32'h3A5C);
    #2 nReset = 1'b0; rst_count++;
    #1;
    chk("async_rst_lutreq", 32'(LutReq), 32'd0);
    chk("async_rst_outvalid", 32'(OutValid), 32'd0);
    chk("async_rst_inready", 32'(InReady), 32'd1);
    chk("async_rst_count", 32'(TokenCount), 32'd0);
    chk("async_rst_lutbits", 32'(LutBits), 32'd0);
    @(negedge Clk);
    #2 nReset = 1'b1; resp_mode = 2;
    repeat (4) begin
      @(negedge Clk);
      chk("late_ack_no_out", 32'(OutValid), 32'd0);
      chk("late_ack_no_req", 32'(LutReq), 32'd0);
    end
    #1 resp_mode = 0;
    @(negedge Clk);

    // Randomized tokens
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(3);
      w = 16'($urandom);
      case (r)
        0: begin
          nc = -1;
          if ($urandom_range(1) == 1) begin
            i = $urandom_range(13);
            w = 16'((cval[i] << (16 - clen[i])) | ($urandom & ((1 << (16 - clen[i])) - 1)));
          end
        end
        1: begin
          nc = $urandom_range(31, 8);
          if ($urandom_range(2) == 0) begin
            case ($urandom_range(2))
              0: w = 16'h0800 | 16'($urandom_range(1023));
              1: w = 16'h0C00 | 16'($urandom_range(1023));
              default: w = 16'h1C00 | 16'($urandom_range(1023));
            endcase
          end
        end
        2: nc = $urandom_range(7, 0);
        default: nc = -int'($urandom_range(32, 2));
      endcase
      issue(w, nc, ($urandom_range(7) == 0) ? 3 : 0, $urandom_range(3), rand_lut());
    end

    n = 0;
    while ((expq.size() != 0 || lutq.size() != 0 || OutValid) && n < 1000) begin
      @(negedge Clk); n++;
    end
    chk("drain", 32'(expq.size() + lutq.size()), 32'd0);
    repeat (2) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
